dsp_fe_lane_align_ctrl: RTL and testbench

Word-alignment and enable sequencer for the ADC front-end lanes. It trains each deserializer lane in turn: it compares the DES output word against a fixed training pattern and pulses a per-lane bitslip until the word matches for a run of consecutive cycles. When all lanes are trained, it releases the retimer enables of the DES-to-LUT lane glue for every locked lane. It sits between the front-end control registers and the per-lane DES/glue instances.

---
 rtl/dsp_fe_lane_align_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dsp_fe_lane_align_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_fe_lane_align_ctrl.sv
// Lane word-alignment sequencer: trains each DES lane against a fixed pattern
// by pulsing bitslip, then releases the retimer enables of the locked lanes.
module dsp_fe_lane_align_ctrl #(
  parameter int unsigned              NUM_LANES     = 6,
  parameter int unsigned              DES_OUT_WIDTH = 4,
  parameter logic [DES_OUT_WIDTH-1:0] TRAIN_PATTERN = 4'b0011,
  parameter int unsigned              SETTLE_CYCLES = 4,
  parameter int unsigned              CHECK_CYCLES  = 8,
  parameter int unsigned              MAX_SLIPS     = DES_OUT_WIDTH - 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [DES_OUT_WIDTH-1:0] i_des_word [NUM_LANES],
  output logic [NUM_LANES-1:0]     o_slip,
  output logic [NUM_LANES-1:0]     o_en,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [NUM_LANES-1:0]     o_lane_locked,
  output logic [NUM_LANES-1:0]     o_lane_fail
);

  localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MCH_W  = $clog2(CHECK_CYCLES + 1);
  localparam int unsigned SLP_W  = (MAX_SLIPS > 0) ? $clog2(MAX_SLIPS + 1) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e               state_q,  state_d;
  logic [LANE_W-1:0]    lane_q,   lane_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [MCH_W-1:0]     match_q,  match_d;
  logic [SLP_W-1:0]     slips_q,  slips_d;
  logic [NUM_LANES-1:0] locked_q, locked_d;
  logic [NUM_LANES-1:0] fail_q,   fail_d;
  logic [NUM_LANES-1:0] slip_q,   slip_d;
  logic [NUM_LANES-1:0] en_q,     en_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [NUM_LANES-1:0] lane_mask;
  logic                 word_ok;

  // Current lane as a one-hot mask, and its pattern comparison
  always_comb begin
    lane_mask = NUM_LANES'(1) << lane_q;
    word_ok   = (i_des_word[lane_q] == TRAIN_PATTERN);
  end

  // Next-state logic and registered-output precompute
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    settle_d = settle_q;
    match_d  = match_q;
    slips_d  = slips_q;
    locked_d = locked_q;
    fail_d   = fail_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d  = ST_SETTLE;
          lane_d   = '0;
          settle_d = '0;
          slips_d  = '0;
          locked_d = '0;
          fail_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_CHECK;
          match_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_CHECK: begin
        if (word_ok) begin
          if (match_q == MCH_W'(CHECK_CYCLES - 1)) begin
            locked_d = locked_q | lane_mask;
            state_d  = ST_NEXT;
          end else begin
            match_d = match_q + MCH_W'(1);
          end
        end else if (slips_q < SLP_W'(MAX_SLIPS)) begin
          state_d = ST_SLIP;
        end else begin
          fail_d  = fail_q | lane_mask;
          state_d = ST_NEXT;
        end
      end
      ST_SLIP: begin
        if (slips_q != SLP_W'(MAX_SLIPS)) begin
          slips_d = slips_q + SLP_W'(1);
        end
        settle_d = '0;
        state_d  = ST_SETTLE;
      end
      ST_NEXT: begin
        if (lane_q == LANE_W'(NUM_LANES - 1)) begin
          state_d = ST_DONE;
        end else begin
          lane_d   = lane_q + LANE_W'(1);
          slips_d  = '0;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they register with it
    slip_d = (state_d == ST_SLIP) ? (NUM_LANES'(1) << lane_d) : '0;
    en_d   = (state_d == ST_DONE) ? locked_d : '0;
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK) ||
             (state_d == ST_SLIP)   || (state_d == ST_NEXT);
  end

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      lane_q   <= '0;
      settle_q <= '0;
      match_q  <= '0;
      slips_q  <= '0;
      locked_q <= '0;
      fail_q   <= '0;
      slip_q   <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      settle_q <= settle_d;
      match_q  <= match_d;
      slips_q  <= slips_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
      slip_q   <= slip_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_slip        = slip_q;
  assign o_en          = en_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_lane_locked = locked_q;
  assign o_lane_fail   = fail_q;

endmodule

// File: tb/tb_dsp_fe_lane_align_ctrl.sv
// Bench for the lane alignment sequencer: a per-lane DES model that rotates
// its word on every bitslip, and a lane-level timing/outcome reference model.
module tb_dsp_fe_lane_align_ctrl;

  localparam int unsigned NL  = 6;
  localparam int unsigned W   = 4;
  localparam int unsigned SC  = 4;
  localparam int unsigned CC  = 8;
  localparam int unsigned MS  = W - 1;
  localparam logic [W-1:0] PAT = 4'b0011;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [W-1:0]  i_des_word [NL];
  logic [NL-1:0] o_slip, o_en, o_lane_locked, o_lane_fail;
  logic          o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Lane model configuration
  int off   [NL];
  bit dead  [NL];
  bit fixed [NL];
  int slips [NL];
  int slip_t [NL][$];
  bit bad0;
  int glitch_n;

  dsp_fe_lane_align_ctrl #(
    .NUM_LANES(NL), .DES_OUT_WIDTH(W), .TRAIN_PATTERN(PAT),
    .SETTLE_CYCLES(SC), .CHECK_CYCLES(CC), .MAX_SLIPS(MS)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_des_word(i_des_word), .o_slip(o_slip), .o_en(o_en),
    .o_busy(o_busy), .o_done(o_done),
    .o_lane_locked(o_lane_locked), .o_lane_fail(o_lane_fail)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] p, input int r);
    logic [W-1:0] v;
    v = p;
    for (int i = 0; i < r; i++) v = {v[W-2:0], v[W-1]};
    return v;
  endfunction

  // DES model: every observed slip pulse rotates the lane word by one bit
  always @(negedge i_clk) begin
    for (int l = 0; l < NL; l++) if (o_slip[l] === 1'b1) slips[l] = slips[l] + 1;
  end

  always_comb begin
    for (int l = 0; l < NL; l++) begin
      i_des_word[l] = rotl(PAT, (off[l] + slips[l]) % W);
      if (fixed[l]) i_des_word[l] = PAT;
      if (dead[l])  i_des_word[l] = '0;
      if (l == 0 && bad0) i_des_word[l] = ~PAT;
    end
  end

  // Reference: cycles a lane costs, number of slips it needs, and outcome
  function automatic int lane_cost(input int o, input bit d, output int ns, output bit lk);
    if (d) begin
      ns = MS; lk = 1'b0;
      return SC + ns * (1 + 1 + SC) + 1 + 1;
    end
    ns = (W - o) % W; lk = 1'b1;
    return SC + ns * (1 + 1 + SC) + CC + 1;
  endfunction

  task automatic configure();
    for (int l = 0; l < NL; l++) begin
      off[l] = 0; dead[l] = 0; fixed[l] = 0; slips[l] = 0;
      slip_t[l].delete();
    end
    bad0 = 0; glitch_n = 0;
  endtask

  task automatic pulse_start();
    @(negedge i_clk); i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  // Runs cycles after the start edge until o_done; n = edges since start edge
  task automatic run_to_done(input int mid_start, output int t_done);
    bit onehot_ok;
    onehot_ok = 1;
    t_done = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = (n == mid_start);
      bad0 = ((n + 1) == glitch_n);
      if ($countones(o_slip) > 1) onehot_ok = 0;
      for (int l = 0; l < NL; l++) if (o_slip[l]) slip_t[l].push_back(n);
      if (o_done) begin t_done = n; break; end
    end
    i_start = 1'b0; bad0 = 0;
    n_checks++;
    if (!onehot_ok) begin n_fail++; $display("FAIL slip_onehot: more than one o_slip bit seen at once"); end
    n_checks++;
    if (t_done < 0) begin n_fail++; $display("FAIL done_timeout: o_done never rose within 2000 cycles"); end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0;
    configure();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({o_slip, o_en, o_busy, o_done, o_lane_locked, o_lane_fail} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got slip=%h en=%h busy=%b done=%b lk=%h fl=%h, want all 0",
                         o_slip, o_en, o_busy, o_done, o_lane_locked, o_lane_fail);
    end
  endtask

  task automatic test_aligned();
    int t;
    configure();
    pulse_start();
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_fail++; $display("FAIL start_busy: busy=%b done=%b, want busy=1 done=0", o_busy, o_done);
    end
    run_to_done(0, t);
    n_checks++;
    if (t != 6 * (SC + CC + 1)) begin n_fail++; $display("FAIL aligned_time: done after %0d edges, want %0d", t, 6 * (SC + CC + 1)); end
    n_checks++;
    if (o_lane_locked !== 6'h3F || o_lane_fail !== 6'h00 || o_en !== 6'h3F) begin
      n_fail++; $display("FAIL aligned_status: lk=%h fl=%h en=%h, want 3f 00 3f", o_lane_locked, o_lane_fail, o_en);
    end
    n_checks++;
    if (slips.sum() != 0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL aligned_slips: slips=%0d busy=%b, want 0 0", slips.sum(), o_busy);
    end
  endtask

  task automatic test_misaligned();
    int t;
    configure();
    off[2] = 2;
    pulse_start();
    run_to_done(0, t);
    n_checks++;
    if (slip_t[2].size() != 2 || slips.sum() != 2) begin
      n_fail++; $display("FAIL mis_slip_count: lane2=%0d total=%0d, want 2 2", slip_t[2].size(), slips.sum());
    end else begin
      n_checks++;
      if (slip_t[2][1] - slip_t[2][0] - 1 != SC + 1) begin
        n_fail++; $display("FAIL mis_slip_gap: %0d quiet cycles between slips, want %0d", slip_t[2][1] - slip_t[2][0] - 1, SC + 1);
      end
    end
    n_checks++;
    if (o_lane_locked !== 6'h3F || o_lane_fail !== 6'h00) begin
      n_fail++; $display("FAIL mis_status: lk=%h fl=%h, want 3f 00", o_lane_locked, o_lane_fail);
    end
    n_checks++;
    if (t != 78 + 2 * (SC + 2)) begin n_fail++; $display("FAIL mis_time: %0d, want %0d", t, 78 + 2 * (SC + 2)); end
  endtask

  task automatic test_dead();
    int t;
    configure();
    dead[4] = 1;
    pulse_start();
    run_to_done(0, t);
    n_checks++;
    if (slip_t[4].size() != 3 || slips.sum() != 3) begin
      n_fail++; $display("FAIL dead_slips: lane4=%0d total=%0d, want 3 3", slip_t[4].size(), slips.sum());
    end
    n_checks++;
    if (o_lane_fail !== 6'h10 || o_lane_locked !== 6'h2F || o_en !== 6'h2F) begin
      n_fail++; $display("FAIL dead_status: fl=%h lk=%h en=%h, want 10 2f 2f", o_lane_fail, o_lane_locked, o_en);
    end
    n_checks++;
    if (t != 89) begin n_fail++; $display("FAIL dead_time: %0d, want 89", t); end
  endtask

  task automatic test_late_mismatch();
    int t;
    configure();
    fixed[0] = 1;
    glitch_n = SC + CC;
    pulse_start();
    run_to_done(0, t);
    n_checks++;
    if (slip_t[0].size() != 1 || slips.sum() != 1) begin
      n_fail++; $display("FAIL late_slips: lane0=%0d total=%0d, want 1 1", slip_t[0].size(), slips.sum());
    end else begin
      n_checks++;
      if (slip_t[0][0] != SC + CC) begin n_fail++; $display("FAIL late_slip_time: %0d, want %0d", slip_t[0][0], SC + CC); end
    end
    n_checks++;
    if (o_lane_locked !== 6'h3F || o_lane_fail !== 6'h00) begin
      n_fail++; $display("FAIL late_status: lk=%h fl=%h, want 3f 00", o_lane_locked, o_lane_fail);
    end
    n_checks++;
    if (t != 78 + 1 + SC + CC) begin n_fail++; $display("FAIL late_time: %0d, want %0d", t, 78 + 1 + SC + CC); end
  endtask

  task automatic test_restart();
    int t;
    configure();
    dead[1] = 1;
    pulse_start();
    run_to_done(20, t);
    n_checks++;
    if (t != 89 || o_lane_fail !== 6'h02 || o_lane_locked !== 6'h3D) begin
      n_fail++; $display("FAIL busy_start_ignored: t=%0d fl=%h lk=%h, want 89 02 3d", t, o_lane_fail, o_lane_locked);
    end
    configure();
    pulse_start();
    n_checks++;
    if (o_en !== '0 || o_lane_locked !== '0 || o_lane_fail !== '0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_clear: en=%h lk=%h fl=%h done=%b busy=%b, want 0 0 0 0 1",
                         o_en, o_lane_locked, o_lane_fail, o_done, o_busy);
    end
    run_to_done(0, t);
    n_checks++;
    if (t != 78 || o_lane_locked !== 6'h3F || o_en !== 6'h3F) begin
      n_fail++; $display("FAIL restart_retrain: t=%0d lk=%h en=%h, want 78 3f 3f", t, o_lane_locked, o_en);
    end
  endtask

  task automatic test_random();
    int t, exp_t, ns [NL];
    bit lk [NL];
    logic [NL-1:0] exp_lk, exp_fl;
    for (int it = 0; it < 4; it++) begin
      configure();
      exp_t = 0; exp_lk = '0; exp_fl = '0;
      for (int l = 0; l < NL; l++) begin
        off[l]  = int'($urandom_range(0, W - 1));
        dead[l] = ($urandom_range(0, 5) == 0);
        exp_t += lane_cost(off[l], dead[l], ns[l], lk[l]);
        exp_lk[l] = lk[l];
        exp_fl[l] = ~lk[l];
      end
      pulse_start();
      run_to_done(0, t);
      n_checks++;
      if (t != exp_t) begin n_fail++; $display("FAIL rand_time[%0d]: %0d, want %0d", it, t, exp_t); end
      n_checks++;
      if (o_lane_locked !== exp_lk || o_lane_fail !== exp_fl || o_en !== exp_lk) begin
        n_fail++; $display("FAIL rand_status[%0d]: lk=%h fl=%h en=%h, want %h %h %h",
                           it, o_lane_locked, o_lane_fail, o_en, exp_lk, exp_fl, exp_lk);
      end
      for (int l = 0; l < NL; l++) begin
        n_checks++;
        if (slip_t[l].size() != ns[l]) begin
          n_fail++; $display("FAIL rand_slips[%0d] lane %0d: %0d, want %0d", it, l, slip_t[l].size(), ns[l]);
        end
        for (int s = 1; s < slip_t[l].size(); s++) begin
          n_checks++;
          if (slip_t[l][s] - slip_t[l][s-1] != SC + 2) begin
            n_fail++; $display("FAIL rand_slip_gap[%0d] lane %0d: %0d, want %0d", it, l, slip_t[l][s] - slip_t[l][s-1], SC + 2);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen, quiet;
    configure();
    off[3] = 1;
    pulse_start();
    seen = 0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge i_clk);
      if (o_slip[3]) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rst_mid_reach: lane 3 slip never seen, want it"); end
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_slip, o_en, o_busy, o_done, o_lane_locked, o_lane_fail} !== '0) begin
      n_fail++; $display("FAIL rst_mid_async: slip=%h en=%h busy=%b done=%b lk=%h fl=%h, want all 0",
                         o_slip, o_en, o_busy, o_done, o_lane_locked, o_lane_fail);
    end
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    quiet = 1;
    repeat (40) begin
      @(negedge i_clk);
      if (o_busy !== 1'b0 || o_done !== 1'b0 || o_slip !== '0 || o_lane_locked !== '0) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin n_fail++; $display("FAIL rst_mid_idle: activity after reset without start, want none"); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned();
    test_dead();
    test_late_mismatch();
    test_restart();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
